// File: rtl/qk_pair_issuer_pkg.sv
// Shared types for the QK pair issuer: vector
// geometry, element type and FSM state encoding.
package qk_pair_issuer_pkg;

  localparam int DK        = 64;
  localparam int INT_WIDTH = 8;
  localparam int BC        = 16;
  localparam int BR        = 16;

  typedef logic signed [INT_WIDTH-1:0] INT_T;
  typedef INT_T [DK-1:0] Q_VECTOR_T;
  typedef INT_T [DK-1:0] K_VECTOR_T;

  typedef enum logic [1:0] {
    ST_LOAD_K = 2'd0,
    ST_WAIT_Q = 2'd1,
    ST_ISSUE  = 2'd2
  } qk_issue_state_t;

endpackage

// File: rtl/qk_pair_issuer_k_tile_buffer.sv
// K tile register file: one synchronous write port,
// one combinational read port, cleared on reset.
module k_tile_buffer
  import qk_pair_issuer_pkg::*;
#(
  parameter int DEPTH = BC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  K_VECTOR_T                i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output K_VECTOR_T                o_rdata
);

  K_VECTOR_T r_mem [DEPTH];

  // Store an incoming K vector at its tile slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/qk_pair_issuer.sv
// Streams every (q_r, k_c) pair of a tile in
// row-major order, with a one-deep Q prefetch.
module qk_pair_issuer
  import qk_pair_issuer_pkg::*;
#(
  parameter int P_BC = BC,
  parameter int P_BR = BR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    k_vld_in,
  output logic                    k_rdy_out,
  input  K_VECTOR_T               k_in,
  input  logic                    q_vld_in,
  output logic                    q_rdy_out,
  input  Q_VECTOR_T               q_in,
  output logic                    vld_out,
  input  logic                    rdy_in,
  output Q_VECTOR_T               q_out,
  output K_VECTOR_T               k_out,
  output logic [$clog2(P_BR)-1:0] row_idx_out,
  output logic [$clog2(P_BC)-1:0] col_idx_out,
  output logic                    last_col_out,
  output logic                    last_row_out,
  output logic                    tile_done_out
);

  localparam int CW = $clog2(P_BC);
  localparam int RW = $clog2(P_BR);
  localparam int AW = $clog2(P_BR + 1);

  localparam logic [CW-1:0] L_CLAST = CW'(P_BC - 1);
  localparam logic [RW-1:0] L_RLAST = RW'(P_BR - 1);
  localparam logic [AW-1:0] L_QMAX  = AW'(P_BR);

  qk_issue_state_t r_state;
  logic [CW-1:0]   r_kcnt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [AW-1:0]   r_qacc;
  Q_VECTOR_T       r_qreg;
  Q_VECTOR_T       r_qnext;
  logic            r_qnext_vld;
  logic            r_done;

  logic      w_k_hs;
  logic      w_q_hs;
  logic      w_o_hs;
  logic      w_qroom;
  logic      w_last_col;
  logic      w_last_row;
  K_VECTOR_T w_kbuf_rd;

  assign w_qroom    = r_qacc < L_QMAX;
  assign w_last_col = r_col == L_CLAST;
  assign w_last_row = r_row == L_RLAST;

  assign k_rdy_out = r_state == ST_LOAD_K;
  assign q_rdy_out = w_qroom &&
    ((r_state == ST_WAIT_Q) ||
     (r_state == ST_ISSUE && !r_qnext_vld));
  assign vld_out   = r_state == ST_ISSUE;

  assign w_k_hs = k_vld_in && k_rdy_out;
  assign w_q_hs = q_vld_in && q_rdy_out;
  assign w_o_hs = vld_out && rdy_in;

  assign q_out         = r_qreg;
  assign k_out         = w_kbuf_rd;
  assign row_idx_out   = r_row;
  assign col_idx_out   = r_col;
  assign last_col_out  = w_last_col;
  assign last_row_out  = w_last_row;
  assign tile_done_out = r_done;

  k_tile_buffer #(
    .DEPTH (P_BC)
  ) u_kbuf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_k_hs),
    .i_waddr (r_kcnt),
    .i_wdata (k_in),
    .i_raddr (r_col),
    .o_rdata (w_kbuf_rd)
  );

  // Tile sequencing: load K, then walk rows and columns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOAD_K;
      r_kcnt      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_qacc      <= '0;
      r_qreg      <= '0;
      r_qnext     <= '0;
      r_qnext_vld <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_LOAD_K: begin
          if (w_k_hs) begin
            if (r_kcnt == L_CLAST) begin
              r_kcnt  <= '0;
              r_state <= ST_WAIT_Q;
            end else begin
              r_kcnt <= r_kcnt + 1'b1;
            end
          end
        end
        ST_WAIT_Q: begin
          if (w_q_hs) begin
            r_qreg  <= q_in;
            r_qacc  <= r_qacc + 1'b1;
            r_col   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_q_hs) begin
            r_qacc <= r_qacc + 1'b1;
          end
          // An incoming Q bypasses qnext when it is
          // needed right now for the next row.
          if (w_q_hs && !(w_o_hs && w_last_col)) begin
            r_qnext     <= q_in;
            r_qnext_vld <= 1'b1;
          end
          if (w_o_hs && !w_last_col) begin
            r_col <= r_col + 1'b1;
          end else if (w_o_hs) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row   <= '0;
              r_qacc  <= '0;
              r_done  <= 1'b1;
              r_state <= ST_LOAD_K;
            end else begin
              r_row <= r_row + 1'b1;
              if (r_qnext_vld) begin
                r_qreg      <= r_qnext;
                r_qnext_vld <= 1'b0;
              end else if (w_q_hs) begin
                r_qreg <= q_in;
              end else begin
                r_state <= ST_WAIT_Q;
              end
            end
          end
        end
        default: r_state <= ST_LOAD_K;
      endcase
    end
  end

endmodule
